bram_frame_reader: RTL and testbench
====================================

// Module: bram_frame_reader
// PURPOSE
//  Read side of the 1-bit 320x240 dual-port frame buffer: drives port B (addrb), captures doutb.
//  Emits the frame in raster order as a valid/ready pixel stream with SOF/EOL/EOF sideband.
//  Hides BRAM read latency and absorbs downstream backpressure with a credit-limited skid FIFO.
//  Sits between the frame buffer and display/processing stages on the read clock domain.
// PARAMETERS
//  IM_WIDTH    320  pixels per line
//  IM_HEIGHT   240  lines per frame
//  ADDR_WIDTH  17   BRAM address width; must hold IM_WIDTH*IM_HEIGHT-1
//  RD_LATENCY  1    BRAM port-B read latency in cycles (1 or 2)
// PORTS
//  clk        in   1           read clock (same clock as BRAM clkb)
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           pulse: begin reading one frame
//  busy       out  1           high from accepted start until done
//  done       out  1           one-cycle pulse after last pixel handshake
//  addrb      out  ADDR_WIDTH  BRAM port-B read address
//  doutb      in   1           BRAM port-B read data
//  out_data   out  1           pixel value
//  out_valid  out  1           pixel valid
//  out_ready  in   1           downstream accepts pixel
//  out_sof    out  1           qualifies pixel at address 0
//  out_eol    out  1           qualifies pixel at x==IM_WIDTH-1
//  out_eof    out  1           qualifies pixel at address IM_WIDTH*IM_HEIGHT-1
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): addrb=0, out_data=0, out_valid=0, sof/eol/eof=0,
//    busy=0, done=0, FIFO empty, in-flight count 0, x/y counters 0, state IDLE.
//  - Reset is synchronously released by the flops; first action possible on 2nd clk after deassert.
//  - FSM IDLE -> READ on start; READ -> DRAIN after issuing address IM_WIDTH*IM_HEIGHT-1;
//    DRAIN -> IDLE when last pixel handshakes (done pulses that same transition).
//  - start while busy ignored. start in cycle done=1 is ignored (state still DRAIN then).
//  - Read issue: in READ, one address per cycle when (fifo_count + inflight) < RD_LATENCY+1.
//    Issued read tag (sof/eol/eof) delayed RD_LATENCY cycles, then written with doutb into FIFO.
//  - FIFO depth RD_LATENCY+1; credit rule guarantees no overflow; full throughput 1 pix/clk
//    when out_ready held high.
//  - addrb increments by 1 per issued read; x wraps IM_WIDTH-1 -> 0 with y+1; after last
//    address addrb returns to 0.
//  - out_* are FIFO head; out_valid=1 whenever FIFO non-empty; data/flags stable while
//    out_valid=1 and out_ready=0. Pop on out_valid & out_ready.
//  - Simultaneous push and pop in one cycle: count unchanged, order preserved.
//  - First pixel latency from start: RD_LATENCY+2 cycles to out_valid.
// CONFIGURATION
//  FRAME_READER_CONT_EN defined: in READ after issuing last address, issue address 0 next
//    (credit permitting) and continue without start; busy stays 1; done pulses on each eof
//    handshake; DRAIN unused. Leaving continuous mode requires rst_n.
//  Not defined: single-frame per start as above.
// TESTING (bench params IM_WIDTH=4, IM_HEIGHT=3, RD_LATENCY=1; BRAM model preloaded addr[0])
//  1 reset then start, out_ready=1 -> 12 pixels on 12 consecutive cycles, data 0,1,0,1...;
//    sof on pixel 0, eol on pixels 3,7,11, eof on 11, done 1 cycle after, busy=0.
//  2 out_ready toggled 1/0 each cycle -> same 12 pixels in order, no drop/dup, data stable while stalled.
//  3 out_ready=0 for 20 cycles after start -> addrb stops after 2 issues, FIFO holds 2; release -> all 12.
//  4 start pulsed again mid-frame at pixel 5 -> ignored; exactly 12 pixels, single done.
//  5 rst_n low at pixel 6 -> all outputs 0 same cycle; new start -> full frame from sof at addr 0.
//  6 FRAME_READER_CONT_EN, RD_LATENCY=2 -> 36 pixels over 3 frames gapless, done pulse at each eof.

Source files
------------

// File: rtl/bram_frame_reader.sv
// Raster-order reader for a 1-bit frame buffer: drives BRAM port B and emits a
// valid/ready pixel stream with SOF/EOL/EOF sideband through a credit-limited
// skid FIFO. Ports: clk, rst_n (async, active low), start, busy, done,
// addrb/doutb (BRAM port B), out_data/out_valid/out_ready, out_sof/eol/eof.
// Optional macro FRAME_READER_CONT_EN: free-running continuous frame mode.
module bram_frame_reader #(
    parameter int IM_WIDTH   = 320,
    parameter int IM_HEIGHT  = 240,
    parameter int ADDR_WIDTH = 17,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic                  doutb,
    output logic                  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof
);
    localparam int DEPTH = RD_LATENCY + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW    = (IM_WIDTH > 1) ? $clog2(IM_WIDTH) : 1;
    localparam int YW    = (IM_HEIGHT > 1) ? $clog2(IM_HEIGHT) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST =
        ADDR_WIDTH'(IM_WIDTH * IM_HEIGHT - 1);
`ifdef FRAME_READER_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_rst_ok;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [RD_LATENCY-1:0] r_pv;
    logic [2:0]            r_pt [RD_LATENCY];
    logic [3:0]            r_fifo [DEPTH];
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [CW-1:0]         r_cnt;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_last_addr;
    logic                  w_frame_end;
    logic [CW-1:0]         w_inflight;
    logic [CW:0]           w_used;
    logic [2:0]            w_tag;
    logic [3:0]            w_head;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_pv[i]);
        end
    end

    assign w_head      = r_fifo[r_rp];
    assign w_valid     = (r_cnt != '0);
    assign w_pop       = w_valid & out_ready;
    assign w_push      = r_pv[RD_LATENCY-1];
    assign w_frame_end = w_pop & w_head[3];
    assign w_last_addr = (r_addr == LAST);
    // A pop this cycle frees its slot in time for the read issued now,
    // which is what sustains one pixel per clock.
    assign w_used  = (CW+1)'(r_cnt) + (CW+1)'(w_inflight)
                   - (CW+1)'(w_pop);
    assign w_issue = (r_state == S_READ) && (w_used < (CW+1)'(DEPTH));
    assign w_tag   = {(r_x == XW'(IM_WIDTH - 1)) &&
                      (r_y == YW'(IM_HEIGHT - 1)),
                      (r_x == XW'(IM_WIDTH - 1)),
                      (r_addr == '0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A start seen in the cycle done is high is dropped, so a frame
    // always needs a fresh start after the done pulse.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start && r_rst_ok && !r_done) w_next = S_READ;
            S_READ:  if (!CONT && w_issue && w_last_addr) w_next = S_DRAIN;
            S_DRAIN: if (w_frame_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = r_done;
        addrb     = r_addr;
        out_valid = w_valid;
        out_data  = w_valid & w_head[0];
        out_sof   = w_valid & w_head[1];
        out_eol   = w_valid & w_head[2];
        out_eof   = w_valid & w_head[3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_ok <= 1'b0;
            r_done   <= 1'b0;
            r_addr   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_pv     <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < RD_LATENCY; i++) r_pt[i] <= '0;
            for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            r_rst_ok <= 1'b1;
            r_done   <= w_frame_end;
            if (w_issue) begin
                if (w_last_addr) begin
                    r_addr <= '0;
                    r_x    <= '0;
                    r_y    <= '0;
                end else begin
                    r_addr <= r_addr + 1'b1;
                    if (r_x == XW'(IM_WIDTH - 1)) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
            end
            // Tag travels alongside the BRAM read so it meets doutb.
            r_pv[0] <= w_issue;
            r_pt[0] <= w_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pt[i] <= r_pt[i-1];
            end
            if (w_push) begin
                r_fifo[r_wp] <= {r_pt[RD_LATENCY-1], doutb};
                r_wp         <= f_inc(r_wp);
            end
            if (w_pop) r_rp <= f_inc(r_rp);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_bram_frame_reader.sv
// Directed bench for bram_frame_reader on a 4x3 frame; BRAM holds addr[0].
// Default build covers single-frame tests; FRAME_READER_CONT_EN covers streaming.
module tb_bram_frame_reader;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = 4;
`ifdef FRAME_READER_CONT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] addrb;
    logic          doutb;
    logic          out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic          d1 = 1'b0;
    logic          d2 = 1'b0;
    int            n_asserts = 0;
    int            n_fail = 0;

    bram_frame_reader #(
        .IM_WIDTH(W), .IM_HEIGHT(H), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .addrb(addrb), .doutb(doutb), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1 <= addrb[0];
        d2 <= d1;
    end
    assign doutb = (LAT == 1) ? d1 : d2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, " valid"}, out_valid, 0);
        chk({tag, " data"}, out_data, 0);
        chk({tag, " flags"}, {out_sof, out_eol, out_eof}, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " addrb"}, addrb, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // rmode 0: ready high; 1: ready toggles. start_at<0: no extra start.
    task automatic rx(input string tag, input int npix, input int rmode,
                      input int start_at);
        int idx = 0;
        int cyc = 0;
        int p;
        bit stl = 0;
        bit pe = 0;
        bit inj = 0;
        bit seen = 0;
        logic [4:0] held = '0;
        logic [4:0] obs;
        logic [4:0] ex;
        while (idx < npix && cyc < 1000) begin
            start = 1'b0;
            if (!inj && idx == start_at) begin
                start = 1'b1;
                inj = 1'b1;
            end
            out_ready = (rmode == 0) ? 1'b1 : ((cyc % 2) == 0);
            obs = {out_valid, out_eof, out_eol, out_sof, out_data};
            chk({tag, " busy"}, busy, 1);
            chk({tag, " done"}, done, pe);
            if (stl) chk({tag, " stall hold"}, obs, held);
            if (rmode == 0 && seen) chk({tag, " gapless"}, out_valid, 1);
            pe = 0;
            stl = 0;
            if (out_valid) begin
                seen = 1;
                if (out_ready) begin
                    p = idx % N;
                    ex = {1'b1, p == N - 1, (p % W) == W - 1, p == 0,
                          p[0]};
                    chk($sformatf("%s pix%0d", tag, idx), obs, ex);
                    pe = out_eof;
                    idx++;
                end else begin
                    stl = 1;
                    held = obs;
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk({tag, " count"}, idx, npix);
    endtask

    initial begin
        int lat;
        int hs;
        tick();
        tick();
        chk_idle_outs("reset");
        rst_n = 1'b1;
        tick();
        tick();
`ifdef FRAME_READER_CONT_EN
        out_ready = 1'b1;
        pulse_start();
        rx("cont", 3 * N, 0, -1);
        chk("cont last done", done, 1);
        chk("cont busy", busy, 1);
        tick();
        chk("cont done clr", done, 0);
        chk("cont still busy", busy, 1);
`else
        out_ready = 1'b1;
        pulse_start();
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("t1 latency", lat, LAT + 2);
        rx("t1", N, 0, -1);
        chk("t1 done", done, 1);
        chk("t1 busy", busy, 0);
        pulse_start();
        chk("t1 start@done busy", busy, 0);
        chk("t1 done clr", done, 0);
        chk("t1 no dup", out_valid, 0);
        tick();

        pulse_start();
        rx("t2", N, 1, -1);
        chk("t2 done", done, 1);
        tick();
        chk("t2 done clr", done, 0);
        chk("t2 idle", busy, 0);

        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) tick();
        chk("t3 addr held", addrb, 2);
        chk("t3 valid", out_valid, 1);
        chk("t3 head sof", {out_sof, out_data}, 2'b10);
        chk("t3 fifo cnt", dut.r_cnt, 2);
        rx("t3", N, 0, -1);
        chk("t3 done", done, 1);
        tick();

        out_ready = 1'b1;
        pulse_start();
        rx("t4", N, 0, 5);
        chk("t4 done", done, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4 single done", done, 0);
            chk("t4 no restart", busy | out_valid, 0);
        end

        pulse_start();
        hs = 0;
        lat = 0;
        while (hs < 6 && lat < 100) begin
            if (out_valid && out_ready) hs++;
            tick();
            lat++;
        end
        chk("t5 reached pix6", hs, 6);
        chk("t5 pre valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outs("t5 reset");
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk_idle_outs("t5 post");
        pulse_start();
        rx("t5", N, 0, -1);
        chk("t5 done", done, 1);
        tick();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end
endmodule
